// File: rtl/instr_pkg.sv
// Shared instruction-set constants: formats, sub-op codes, conditions, STP word.
// Used by the encoder, the decoder and the assembler.
package instr_pkg;

    typedef enum logic [2:0] {
        FMT_SR   = 3'd0,
        FMT_SRBA = 3'd1,
        FMT_DR   = 3'd2,
        FMT_TR   = 3'd3,
        FMT_DA   = 3'd4,
        FMT_CTL  = 3'd5,
        FMT_BR   = 3'd6
    } fmt_t;

    localparam logic [6:0] SR_LDI   = 7'h0A;
    localparam logic [6:0] SR_AIM   = 7'h0B;
    localparam logic [6:0] SR_SIM   = 7'h0C;
    localparam logic [6:0] DR_ADD   = 7'h00;
    localparam logic [6:0] DA_JMD   = 7'h00;
    localparam logic [6:0] DA_CALL  = 7'h01;
    localparam logic [6:0] DA_LDA   = 7'h02;
    localparam logic [6:0] CTL_RTN  = 7'h00;
    localparam logic [6:0] CTL_STP  = 7'h01;
    localparam logic [6:0] CTL_MAX  = 7'h10;

    localparam logic [3:0] COND_ALWAYS  = 4'b0110;
    localparam logic [3:0] COND_INVALID = 4'b1110;

    localparam logic [15:0] STP_WORD = 16'hF016;

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: symbolic fields -> first machine word, immediate flag, illegal flag.
// INSTR_ENC_LEGAL_CHECK_EN enables field legality checking; otherwise illegal is tied low.
module instr_pack
    import instr_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  subop,
    input  logic [3:0]  cond,
    input  logic [2:0]  rd,
    input  logic [2:0]  rs,
    input  logic [2:0]  rb,
    input  logic [3:0]  bitidx,
    input  logic [11:0] addr,
    output logic [15:0] word0,
    output logic        needs_imm,
    output logic        illegal
);

    always_comb begin
        word0     = 16'h0000;
        needs_imm = 1'b0;
        case (fmt)
            FMT_SR: begin
                word0     = {3'b000, subop[5:0], cond, rd};
                // Match on the packed 6-bit field so the decoder and encoder agree on immediates
                needs_imm = ({1'b0, subop[5:0]} == SR_LDI) ||
                            ({1'b0, subop[5:0]} == SR_AIM) ||
                            ({1'b0, subop[5:0]} == SR_SIM);
            end
            FMT_SRBA: word0 = {3'b001, subop[1:0], cond, rd, bitidx};
            FMT_DR:   word0 = {2'b01, subop[3:0], cond, rd, rs};
            FMT_TR:   word0 = {2'b10, subop[0], cond, rd, rb, rs};
            FMT_DA:   word0 = {2'b11, subop[1:0], addr};
            FMT_CTL:  word0 = {5'b11110, subop[6:0], cond};
            FMT_BR:   word0 = {5'b11111, subop[3:0], cond, 3'b000};
            default:  word0 = 16'h0000;
        endcase
    end

`ifdef INSTR_ENC_LEGAL_CHECK_EN
    always_comb begin
        illegal = (cond == COND_INVALID);
        case (fmt)
            FMT_SR:   if (subop == 7'h01 || subop == 7'h02 || subop > SR_SIM) illegal = 1'b1;
            FMT_DA:   if (subop == 7'h03) illegal = 1'b1;
            FMT_CTL:  if (subop > CTL_MAX) illegal = 1'b1;
            FMT_BR:   if (subop > 7'h01) illegal = 1'b1;
            FMT_SRBA, FMT_DR, FMT_TR: illegal = illegal;
            default:  illegal = 1'b1;
        endcase
    end
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: packs one symbolic instruction per handshake into RAM words, appends STP on finish.
// Latency: write appears the cycle after accept; immediate word follows the next cycle.
// Backpressure: in_ready low in EMIT0/EMIT1 and while a finish is pending (INSTR_ENC_LEGAL_CHECK_EN adds legality errors).
module instr_encoder
    import instr_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        subop,
    input  logic [3:0]        cond,
    input  logic [2:0]        rd,
    input  logic [2:0]        rs,
    input  logic [2:0]        rb,
    input  logic [3:0]        bitidx,
    input  logic [11:0]       addr,
    input  logic [15:0]       imm,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        EMIT0 = 3'd2,
        EMIT1 = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t          state;
    logic [ADDR_W:0] ptr;      // extra MSB marks wrap past the last address
    logic            fin_pend;
    logic            has_imm;
    logic            is_stp;
    logic [15:0]     imm_q;

    logic [15:0] word0;
    logic        needs_imm;
    logic        illegal;

    instr_pack u_pack (
        .fmt       (fmt),
        .subop     (subop),
        .cond      (cond),
        .rd        (rd),
        .rs        (rs),
        .rb        (rb),
        .bitidx    (bitidx),
        .addr      (addr),
        .word0     (word0),
        .needs_imm (needs_imm),
        .illegal   (illegal)
    );

    wire overflow = ptr[ADDR_W];

    assign in_ready = (state == RUN) && !fin_pend;
    assign busy     = (state != IDLE) && (state != DONE) && (state != ERR);
    assign done     = (state == DONE);
    assign err      = (state == ERR);

    // Write strobe is set on the edge entering EMIT0/EMIT1 so it is visible during those states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            fin_pend <= 1'b0;
            has_imm  <= 1'b0;
            is_stp   <= 1'b0;
            imm_q    <= 16'h0000;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 16'h0000;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        ptr      <= {1'b0, base_addr};
                        fin_pend <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (in_valid && in_ready) begin
                        if (finish) fin_pend <= 1'b1;
                        if (illegal || overflow) begin
                            state <= ERR;
                        end else begin
                            wr_en   <= 1'b1;
                            wr_addr <= ptr[ADDR_W-1:0];
                            wr_data <= word0;
                            ptr     <= ptr + 1'b1;
                            imm_q   <= imm;
                            has_imm <= needs_imm;
                            is_stp  <= 1'b0;
                            state   <= EMIT0;
                        end
                    end else if (finish || fin_pend) begin
                        fin_pend <= 1'b0;
                        if (overflow) begin
                            state <= ERR;
                        end else begin
                            wr_en   <= 1'b1;
                            wr_addr <= ptr[ADDR_W-1:0];
                            wr_data <= STP_WORD;
                            ptr     <= ptr + 1'b1;
                            has_imm <= 1'b0;
                            is_stp  <= 1'b1;
                            state   <= EMIT0;
                        end
                    end
                end
                EMIT0: begin
                    if (has_imm) begin
                        if (overflow) begin
                            state <= ERR;
                        end else begin
                            wr_en   <= 1'b1;
                            wr_addr <= ptr[ADDR_W-1:0];
                            wr_data <= imm_q;
                            ptr     <= ptr + 1'b1;
                            state   <= EMIT1;
                        end
                    end else begin
                        state <= is_stp ? DONE : RUN;
                    end
                end
                EMIT1: state <= RUN;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes expected RAM writes, a monitor pops them on wr_en.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] base_addr = '0;
    logic        finish = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  fmt = '0;
    logic [6:0]  subop = '0;
    logic [3:0]  cond = '0;
    logic [2:0]  rd = '0, rs = '0, rb = '0;
    logic [3:0]  bitidx = '0;
    logic [11:0] addr = '0;
    logic [15:0] imm = '0;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;
    logic        busy, done, err;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [11:0] a;
        logic [15:0] d;
    } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;

    instr_encoder #(.ADDR_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .finish(finish), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .subop(subop), .cond(cond), .rd(rd), .rs(rs), .rb(rb),
        .bitidx(bitidx), .addr(addr), .imm(imm),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [11:0] a, input logic [15:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%h@%h required=none", wr_data, wr_addr);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", {20'h0, wr_addr}, {20'h0, mon_e.a});
                chk("wr_data", {16'h0, wr_data}, {16'h0, mon_e.d});
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!in_ready && n < 20) begin
            tick(1);
            n++;
        end
        if (!in_ready) chk({name, "_ready_timeout"}, 32'h0, 32'h1);
    endtask

    task automatic do_start(input logic [11:0] base);
        start = 1'b1;
        base_addr = base;
        tick(1);
        start = 1'b0;
    endtask

    task automatic issue(input string name, input logic [2:0] f, input logic [6:0] so,
                         input logic [3:0] c, input logic [2:0] d_rd, input logic [2:0] d_rs,
                         input logic [2:0] d_rb, input logic [3:0] bi, input logic [11:0] ad,
                         input logic [15:0] im, input logic fin);
        wait_ready(name);
        fmt = f; subop = so; cond = c; rd = d_rd; rs = d_rs; rb = d_rb;
        bitidx = bi; addr = ad; imm = im;
        in_valid = 1'b1;
        finish = fin;
        tick(1);
        in_valid = 1'b0;
        finish = 1'b0;
    endtask

    task automatic pulse_finish();
        wait_ready("finish");
        finish = 1'b1;
        tick(1);
        finish = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
        chk("rst_wr_en",    {31'h0, wr_en},    32'h0);
        chk("rst_wr_addr",  {20'h0, wr_addr},  32'h0);
        chk("rst_wr_data",  {16'h0, wr_data},  32'h0);
        chk("rst_busy",     {31'h0, busy},     32'h0);
        chk("rst_done",     {31'h0, done},     32'h0);
        chk("rst_err",      {31'h0, err},      32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        do_start(12'h010);
        chk("run_busy",  {31'h0, busy},     32'h1);
        chk("run_ready", {31'h0, in_ready}, 32'h1);

        // DR ADD rd2 rs1 cond always
        expect_wr(12'h010, 16'h4191);
        issue("dr_add", 3'd2, 7'h00, 4'b0110, 3'd2, 3'd1, 3'd0, 4'd0, 12'h000, 16'h0, 1'b0);
        chk("dr_emit_ready", {31'h0, in_ready}, 32'h0);

        // SR LDI rd3 imm BEEF: two consecutive writes, ready low for two cycles
        expect_wr(12'h011, 16'h0533);
        expect_wr(12'h012, 16'hBEEF);
        issue("ldi", 3'd0, 7'h0A, 4'b0110, 3'd3, 3'd0, 3'd0, 4'd0, 12'h000, 16'hBEEF, 1'b0);
        chk("ldi_ready_e0", {31'h0, in_ready}, 32'h0);
        tick(1);
        chk("ldi_ready_e1", {31'h0, in_ready}, 32'h0);
        tick(1);
        chk("ldi_ready_run", {31'h0, in_ready}, 32'h1);

        // TR subop1 cond0110 rd1 rb2 rs3
        expect_wr(12'h013, 16'hAC53);
        issue("tr", 3'd3, 7'h01, 4'b0110, 3'd1, 3'd3, 3'd2, 4'd0, 12'h000, 16'h0, 1'b0);
        // SRBA subop2 cond0000 rd5 bit9
        expect_wr(12'h014, 16'h3059);
        issue("srba", 3'd1, 7'h02, 4'b0000, 3'd5, 3'd0, 3'd0, 4'd9, 12'h000, 16'h0, 1'b0);
        // BR subop1 cond0011
        expect_wr(12'h015, 16'hF898);
        issue("br", 3'd6, 7'h01, 4'b0011, 3'd0, 3'd0, 3'd0, 4'd0, 12'h000, 16'h0, 1'b0);
        // CTL RTN cond always
        expect_wr(12'h016, 16'hF006);
        issue("ctl_rtn", 3'd5, 7'h00, 4'b0110, 3'd0, 3'd0, 3'd0, 4'd0, 12'h000, 16'h0, 1'b0);
        // DA JMD 0x123, then a separate finish
        expect_wr(12'h017, 16'hC123);
        issue("da_jmd", 3'd4, 7'h00, 4'b0110, 3'd0, 3'd0, 3'd0, 4'd0, 12'h123, 16'h0, 1'b0);
        expect_wr(12'h018, 16'hF016);
        pulse_finish();
        tick(2);
        chk("fin_done", {31'h0, done}, 32'h1);
        chk("fin_busy", {31'h0, busy}, 32'h0);
        chk("fin_err",  {31'h0, err},  32'h0);

        // Reserved condition code
        do_start(12'h200);
        chk("restart_done", {31'h0, done}, 32'h0);
        chk("restart_busy", {31'h0, busy}, 32'h1);
`ifdef INSTR_ENC_LEGAL_CHECK_EN
        issue("cond_bad", 3'd2, 7'h00, 4'b1110, 3'd0, 3'd0, 3'd0, 4'd0, 12'h000, 16'h0, 1'b0);
        tick(2);
        chk("cond_bad_err",  {31'h0, err},  32'h1);
        chk("cond_bad_busy", {31'h0, busy}, 32'h0);
`else
        expect_wr(12'h200, 16'h4380);
        issue("cond_bad", 3'd2, 7'h00, 4'b1110, 3'd0, 3'd0, 3'd0, 4'd0, 12'h000, 16'h0, 1'b0);
        tick(2);
        chk("cond_bad_err", {31'h0, err}, 32'h0);
        expect_wr(12'h201, 16'hF016);
        pulse_finish();
        tick(2);
        chk("cond_bad_done", {31'h0, done}, 32'h1);
`endif

        // DA CALL with a coincident finish: instruction first, then STP
        do_start(12'h300);
        expect_wr(12'h300, 16'hD456);
        expect_wr(12'h301, 16'hF016);
        issue("call_fin", 3'd4, 7'h01, 4'b0110, 3'd0, 3'd0, 3'd0, 4'd0, 12'h456, 16'h0, 1'b1);
        chk("call_fin_ready", {31'h0, in_ready}, 32'h0);
        tick(4);
        chk("call_fin_done", {31'h0, done}, 32'h1);

        // Last address is writable, the immediate past it overflows
        do_start(12'hFFF);
        expect_wr(12'hFFF, 16'h0533);
        issue("ovf_ldi", 3'd0, 7'h0A, 4'b0110, 3'd3, 3'd0, 3'd0, 4'd0, 12'h000, 16'h1234, 1'b0);
        tick(3);
        chk("ovf_err",  {31'h0, err},  32'h1);
        chk("ovf_busy", {31'h0, busy}, 32'h0);
        chk("ovf_done", {31'h0, done}, 32'h0);

        // Reset while the immediate is on the write port
        do_start(12'h020);
        chk("ovf_restart_err", {31'h0, err}, 32'h0);
        expect_wr(12'h020, 16'h0533);
        issue("rst_ldi", 3'd0, 7'h0A, 4'b0110, 3'd3, 3'd0, 3'd0, 4'd0, 12'h000, 16'hCAFE, 1'b0);
        tick(1);
        chk("emit1_wr_en", {31'h0, wr_en}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_wr_en",    {31'h0, wr_en},    32'h0);
        chk("abort_wr_addr",  {20'h0, wr_addr},  32'h0);
        chk("abort_wr_data",  {16'h0, wr_data},  32'h0);
        chk("abort_busy",     {31'h0, busy},     32'h0);
        chk("abort_in_ready", {31'h0, in_ready}, 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        chk("abort_idle_busy", {31'h0, busy}, 32'h0);
        chk("pending_writes", exp_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
